axis_master_pipe_a1: RTL and testbench
======================================

Name: axis_master_pipe_A1

Overview:
- Forward-path register slice for AXI-Stream. It is the counterpart of the existing ready-path slaver pipe.
- Registers tvalid, tdata, tkeep, tuser and tlast through DEPTH stages. tready stays a combinational chain, so long valid/data routes are timing-cut while ready is not.
- Bubble-collapsing: an empty stage always accepts, so throughput is 1 beat/cycle at any DEPTH.
- Sits between a stream producer and a distant or high-fanout consumer. Often cascaded with the slaver pipe to form a full slice.

Parameters:
- DEPTH, 1: number of register stages; legal range is 1..16.
- DSIZE, 32: tdata width in bits; must be a multiple of 8.
- USIZE, 1: tuser width in bits.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous reset, active-low.
- aclken  in  1  clock enable. When low, all state holds and no transfer occurs.
- in_tvalid  in  1  upstream valid.
- in_tready  out  1  upstream ready.
- in_tdata  in  DSIZE  upstream data.
- in_tkeep  in  DSIZE/8  upstream byte keep.
- in_tuser  in  USIZE  upstream user.
- in_tlast  in  1  upstream end of packet.
- out_tvalid  out  1  downstream valid (registered).
- out_tready  in  1  downstream ready.
- out_tdata  out  DSIZE  downstream data (registered).
- out_tkeep  out  DSIZE/8  downstream keep (registered).
- out_tuser  out  USIZE  downstream user (registered).
- out_tlast  out  1  downstream end of packet (registered).
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered).

Behaviour:
- Clock and reset: single clock aclk. aresetn is asynchronous, active-low.
- Reset values: every stage valid=0 and payload=0; out_tvalid=0; out_tdata/tkeep/tuser/tlast=0; occupancy=0.
- Reset mid-packet: all in-flight beats are discarded. Outputs deassert immediately on reset assertion, with no clock needed.
- Stage model: stage k (0=input side, DEPTH-1=output side) holds v[k] plus a payload. Outputs are driven directly from stage DEPTH-1.
- Ready chain:
  - r[DEPTH] = out_tready.
  - r[k] = !v[k] | r[k+1].
  - in_tready = r[0].
  - The chain is purely combinational, with no register on it.
- Transfer qualification: input transfer = in_tvalid & in_tready & aclken. Output transfer = out_tvalid & out_tready & aclken.
- Per clock edge with aclken=1, for each stage k:
  - If r[k]: v[k] <= v[k-1]; for k=0, v[0] <= in_tvalid.
  - If r[k] and the source is valid: payload[k] <= source payload.
  - If r[k] and the source is invalid: payload is not updated (holds).
  - If !r[k]: the stage holds.
- aclken=0: no state changes, including occupancy. in_tready stays combinationally computed, but no transfer counts.
- AXIS rules:
  - Once out_tvalid=1, it and the payload stay stable until an output transfer.
  - Beat order is preserved.
  - No beat is duplicated or dropped.
  - tlast/tkeep/tuser travel with their beat.
- Latency: a beat accepted at edge N into an empty pipe is visible on the outputs after edge N+DEPTH-1. Equivalently, it is accepted on cycle 0 and presented on cycle DEPTH-1 registered outputs, DEPTH edges after arrival.
- Full (occupancy=DEPTH):
  - in_tready = out_tready.
  - Simultaneous input and output transfer leaves occupancy at DEPTH, and the whole pipe advances.
- Empty (occupancy=0): out_tvalid=0. in_tready=1 regardless of out_tready.
- Occupancy update: occupancy <= occupancy + in_xfer - out_xfer. It never exceeds DEPTH and never wraps.
- Bubble collapse: with out_tready=0, sparse input fills stages back-to-front until all DEPTH stages are valid.

Decomposition:
- Shared package axis_pipe_pkg:
  - Packed struct typedef axis_beat_t (tdata, tkeep, tuser, tlast), parameterised through DSIZE/USIZE localparams.
  - Localparam MAX_PIPE_DEPTH=16.
  - Function occ_width(depth) returning $clog2(depth+1).
- Sub-module axis_master_pipe_stage: one valid+payload register with an r_out = !v | r_in ready term. It is instantiated DEPTH times in a generate loop. The top level holds the ready chain and the occupancy counter.

Test Plan:
- Latency (DEPTH=3, out_tready=1): single beat tdata=0xA5A5_0001 accepted at edge 0 -> out_tvalid=1 with 0xA5A5_0001 after edge 2; occupancy goes 1,1,1 then 0 after output.
- Throughput (DEPTH=3): 16 back-to-back beats 0..15 with tlast on beat 15, out_tready=1 -> 16 consecutive output beats in order, tlast only on 15, occupancy steady at 3, in_tready never low.
- Backpressure (DEPTH=4): out_tready=0, continuous input -> exactly 4 beats accepted, in_tready=0 after that, occupancy=4, out_tdata stable. Raise out_tready -> beats 0..3 drain, then input resumes with no loss.
- Bubble collapse (DEPTH=3): out_tready=0, in_tvalid pulsed every 3rd cycle -> 3 beats accepted, occupancy=3, order 0,1,2 preserved on release.
- aclken: aclken=0 for 5 cycles mid-stream with in_tvalid=out_tready=1 -> no beats move, occupancy and outputs frozen, no beat counted on either side.
- Reset: assert aresetn=0 mid-stream between clock edges with occupancy=2 -> out_tvalid=0 and occupancy=0 immediately. After release, the first new beat appears with DEPTH latency.

Source files
------------

// File: rtl/axis_pipe_pkg.sv
// Shared types and helpers for the AXI-Stream pipe slices.
// The beat struct groups everything that travels with tvalid through a stage.
package axis_pipe_pkg;

   localparam int MAX_PIPE_DEPTH = 16;
   localparam int AXIS_DSIZE     = 32;
   localparam int AXIS_USIZE     = 1;

   typedef struct packed {
      logic [AXIS_DSIZE-1:0]   tdata;
      logic [AXIS_DSIZE/8-1:0] tkeep;
      logic [AXIS_USIZE-1:0]   tuser;
      logic                    tlast;
   } axis_beat_t;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/axis_master_pipe_stage.sv
// One forward register stage: a valid bit plus payload.
// The stage is open whenever it is empty or the stage after it is open.
module axis_master_pipe_stage
   import axis_pipe_pkg::*;
#(
   parameter type beat_t = axis_beat_t
) (
   input  logic  aclk,
   input  logic  aresetn,
   input  logic  aclken,
   input  logic  src_valid,
   input  beat_t src_beat,
   input  logic  r_in,
   output logic  r_out,
   output logic  valid,
   output beat_t beat
);

   assign r_out = !valid || r_in;

   // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid <= 1'b0;
         beat  <= '0;
      end else if (aclken && r_out) begin
         valid <= src_valid;
         if (src_valid) begin
            beat <= src_beat;
         end
      end
   end

endmodule

// File: rtl/axis_master_pipe_a1.sv
// Forward-path AXI-Stream register slice: valid and payload are registered through
// DEPTH bubble-collapsing stages while tready remains a combinational chain.
module axis_master_pipe_a1
   import axis_pipe_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int DSIZE = 32,
   parameter int USIZE = 1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        aclken,
   input  logic                        in_tvalid,
   output logic                        in_tready,
   input  logic [DSIZE-1:0]            in_tdata,
   input  logic [DSIZE/8-1:0]          in_tkeep,
   input  logic [USIZE-1:0]            in_tuser,
   input  logic                        in_tlast,
   output logic                        out_tvalid,
   input  logic                        out_tready,
   output logic [DSIZE-1:0]            out_tdata,
   output logic [DSIZE/8-1:0]          out_tkeep,
   output logic [USIZE-1:0]            out_tuser,
   output logic                        out_tlast,
   output logic [occ_width(DEPTH)-1:0] occupancy
);

   localparam int STAGES = (DEPTH < 1) ? 1 : ((DEPTH > MAX_PIPE_DEPTH) ? MAX_PIPE_DEPTH : DEPTH);
   localparam int OW     = occ_width(DEPTH);

   typedef struct packed {
      logic [DSIZE-1:0]   tdata;
      logic [DSIZE/8-1:0] tkeep;
      logic [USIZE-1:0]   tuser;
      logic               tlast;
   } beat_t;

   beat_t in_beat;
   beat_t out_beat;
   logic  in_xfer;
   logic  out_xfer;

   assign in_beat = '{tdata: in_tdata, tkeep: in_tkeep, tuser: in_tuser, tlast: in_tlast};

   // Stage k is fed by stage k-1 and sees the ready of stage k+1; stage 0 faces the input.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic  src_valid;
      beat_t src_beat;
      logic  rdy_in;
      logic  rdy;
      logic  valid;
      beat_t beat;

      if (k == 0) begin : g_head
         assign src_valid = in_tvalid;
         assign src_beat  = in_beat;
      end else begin : g_body
         assign src_valid = g_stage[k-1].valid;
         assign src_beat  = g_stage[k-1].beat;
      end

      if (k == STAGES - 1) begin : g_tail
         assign rdy_in = out_tready;
      end else begin : g_link
         assign rdy_in = g_stage[k+1].rdy;
      end

      axis_master_pipe_stage #(
         .beat_t (beat_t)
      ) u_stage (
         .aclk      (aclk),
         .aresetn   (aresetn),
         .aclken    (aclken),
         .src_valid (src_valid),
         .src_beat  (src_beat),
         .r_in      (rdy_in),
         .r_out     (rdy),
         .valid     (valid),
         .beat      (beat)
      );
   end

   assign in_tready  = g_stage[0].rdy;
   assign out_tvalid = g_stage[STAGES-1].valid;
   assign out_beat   = g_stage[STAGES-1].beat;

   assign out_tdata  = out_beat.tdata;
   assign out_tkeep  = out_beat.tkeep;
   assign out_tuser  = out_beat.tuser;
   assign out_tlast  = out_beat.tlast;

   assign in_xfer  = in_tvalid && in_tready && aclken;
   assign out_xfer = out_tvalid && out_tready && aclken;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         occupancy <= '0;
      end else if (in_xfer != out_xfer) begin
         occupancy <= in_xfer ? occupancy + OW'(1) : occupancy - OW'(1);
      end
   end

endmodule

// File: tb/tb_axis_master_pipe_a1.sv
// Self-checking bench for axis_master_pipe_a1: a FIFO-queue reference model of the
// beats in flight checks ordering, occupancy, ready and AXIS stability every cycle.
module tb_axis_master_pipe_a1;

   localparam int DEPTH = 3;
   localparam int OCCW  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic [0:0]  u;
      logic        l;
   } tb_beat_t;

   logic            aclk;
   logic            aresetn;
   logic            aclken;
   logic            in_tvalid;
   logic            in_tready;
   tb_beat_t        drv;
   logic            out_tvalid;
   logic            out_tready;
   logic [31:0]     out_tdata;
   logic [3:0]      out_tkeep;
   logic [0:0]      out_tuser;
   logic            out_tlast;
   logic [OCCW-1:0] occupancy;

   int       checks   = 0;
   int       failures = 0;
   tb_beat_t exp_q[$];
   logic     last_in_xfer;
   logic     last_out_xfer;
   logic     hold_pending;
   tb_beat_t held_beat;

   axis_master_pipe_a1 #(
      .DEPTH (DEPTH),
      .DSIZE (32),
      .USIZE (1)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .aclken     (aclken),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .in_tdata   (drv.d),
      .in_tkeep   (drv.k),
      .in_tuser   (drv.u),
      .in_tlast   (drv.l),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tdata  (out_tdata),
      .out_tkeep  (out_tkeep),
      .out_tuser  (out_tuser),
      .out_tlast  (out_tlast),
      .occupancy  (occupancy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic tb_beat_t mk_beat(input int n);
      tb_beat_t b;
      b.d = 32'(n);
      b.k = 4'(n);
      b.u = 1'(n);
      b.l = ((n % 4) == 3);
      return b;
   endfunction

   function automatic tb_beat_t rand_beat();
      tb_beat_t b;
      b.d = $urandom;
      b.k = 4'($urandom);
      b.u = 1'($urandom);
      b.l = 1'($urandom);
      return b;
   endfunction

   // One clock cycle: entered just after a falling edge with inputs already driven.
   task automatic step();
      tb_beat_t ob;
      logic     exp_ready;
      #1;
      ob = {out_tdata, out_tkeep, out_tuser, out_tlast};
      checks++;
      if (occupancy !== OCCW'(exp_q.size())) begin
         failures++;
         $display("FAIL occupancy: got %0d expected %0d", occupancy, exp_q.size());
      end
      exp_ready = (exp_q.size() < DEPTH) || out_tready;
      checks++;
      if (in_tready !== exp_ready) begin
         failures++;
         $display("FAIL in_tready: got %b expected %b (beats held %0d)", in_tready, exp_ready, exp_q.size());
      end
      if (exp_q.size() == 0) begin
         checks++;
         if (out_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL out_tvalid_empty: got %b expected 0", out_tvalid);
         end
      end else if (out_tvalid === 1'b1) begin
         checks++;
         if (ob !== exp_q[0]) begin
            failures++;
            $display("FAIL out_beat_order: got %h expected %h", ob, exp_q[0]);
         end
      end
      if (hold_pending) begin
         checks++;
         if (out_tvalid !== 1'b1 || ob !== held_beat) begin
            failures++;
            $display("FAIL out_stable: got valid=%b beat=%h expected valid=1 beat=%h", out_tvalid, ob, held_beat);
         end
      end
      last_in_xfer  = in_tvalid && in_tready && aclken;
      last_out_xfer = out_tvalid && out_tready && aclken;
      hold_pending  = out_tvalid && !last_out_xfer;
      held_beat     = ob;
      @(posedge aclk);
      if (last_out_xfer && exp_q.size() > 0) void'(exp_q.pop_front());
      if (last_in_xfer) exp_q.push_back(drv);
      @(negedge aclk);
   endtask

   task automatic drain();
      in_tvalid  = 1'b0;
      out_tready = 1'b1;
      aclken     = 1'b1;
      for (int c = 0; c < 4 * DEPTH + 8 && (exp_q.size() != 0 || occupancy !== '0); c++) step();
      checks++;
      if (exp_q.size() != 0 || occupancy !== '0 || out_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL drain: got occupancy=%0d valid=%b expected empty (model holds %0d)", occupancy, out_tvalid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      aresetn    = 1'b0;
      aclken     = 1'b1;
      in_tvalid  = 1'b0;
      out_tready = 1'b0;
      drv        = '0;
      repeat (2) @(negedge aclk);
      checks++;
      if (out_tvalid !== 1'b0 || occupancy !== '0) begin
         failures++;
         $display("FAIL reset_state: got valid=%b occ=%0d expected 0/0", out_tvalid, occupancy);
      end
      checks++;
      if ({out_tdata, out_tkeep, out_tuser, out_tlast} !== '0) begin
         failures++;
         $display("FAIL reset_payload: got %h expected 0", {out_tdata, out_tkeep, out_tuser, out_tlast});
      end
      checks++;
      if (in_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 1", in_tready);
      end
      aresetn = 1'b1;
      exp_q.delete();
      hold_pending = 1'b0;
   endtask

   task automatic test_latency(input logic [31:0] data);
      out_tready = 1'b1;
      in_tvalid  = 1'b1;
      drv        = '{d: data, k: 4'hF, u: 1'b1, l: 1'b1};
      step();
      in_tvalid = 1'b0;
      drv       = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (e > 0) step();
         checks++;
         if (out_tvalid !== 1'(e == DEPTH - 1) || occupancy !== OCCW'(1)) begin
            failures++;
            $display("FAIL latency_edge%0d: got valid=%b occ=%0d expected valid=%b occ=1", e, out_tvalid, occupancy, e == DEPTH - 1);
         end
      end
      checks++;
      if (out_tdata !== data) begin
         failures++;
         $display("FAIL latency_data: got %h expected %h", out_tdata, data);
      end
      step();
      checks++;
      if (occupancy !== '0 || out_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL latency_drain: got occ=%0d valid=%b expected 0/0", occupancy, out_tvalid);
      end
   endtask

   task automatic test_throughput();
      int sent  = 0;
      int got   = 0;
      int first = -1;
      int last  = -1;
      out_tready = 1'b1;
      for (int c = 0; c < 16 + DEPTH + 4; c++) begin
         in_tvalid = (sent < 16);
         drv       = '{d: 32'(sent), k: 4'hF, u: 1'(sent), l: (sent == 15)};
         step();
         if (in_tvalid) begin
            checks++;
            if (!last_in_xfer) begin
               failures++;
               $display("FAIL throughput_ready: got stall on beat %0d expected accept", sent);
            end
         end
         if (last_in_xfer && last_out_xfer) begin
            checks++;
            if (occupancy !== OCCW'(DEPTH)) begin
               failures++;
               $display("FAIL throughput_occ: got %0d expected %0d", occupancy, DEPTH);
            end
         end
         if (last_in_xfer) sent++;
         if (last_out_xfer) begin
            if (first < 0) first = c;
            last = c;
            got++;
         end
      end
      in_tvalid = 1'b0;
      checks++;
      if (got != 16 || last - first != 15) begin
         failures++;
         $display("FAIL throughput_burst: got %0d beats over %0d cycles expected 16 over 16", got, last - first + 1);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      out_tready = 1'b0;
      in_tvalid  = 1'b1;
      for (int c = 0; c < DEPTH + 4; c++) begin
         drv = mk_beat(100 + acc);
         step();
         if (last_in_xfer) acc++;
      end
      checks++;
      if (acc != DEPTH || occupancy !== OCCW'(DEPTH)) begin
         failures++;
         $display("FAIL bp_fill: got accepted=%0d occ=%0d expected %0d", acc, occupancy, DEPTH);
      end
      checks++;
      if (in_tready !== 1'b0 || out_tdata !== 32'd100) begin
         failures++;
         $display("FAIL bp_full: got ready=%b data=%0d expected ready=0 data=100", in_tready, out_tdata);
      end
      out_tready = 1'b1;
      for (int c = 0; c < 2 * DEPTH + 4; c++) begin
         drv = mk_beat(100 + acc);
         step();
         if (last_in_xfer) acc++;
      end
      drain();
   endtask

   task automatic test_bubble();
      int acc = 0;
      out_tready = 1'b0;
      for (int c = 0; c < 3 * DEPTH + 3; c++) begin
         in_tvalid = ((c % 3) == 0) && (acc < DEPTH);
         drv       = mk_beat(200 + acc);
         step();
         if (last_in_xfer) acc++;
      end
      in_tvalid = 1'b0;
      checks++;
      if (acc != DEPTH || occupancy !== OCCW'(DEPTH) || out_tvalid !== 1'b1 || out_tdata !== 32'd200) begin
         failures++;
         $display("FAIL bubble_fill: got acc=%0d occ=%0d valid=%b data=%0d expected %0d/%0d/1/200",
                  acc, occupancy, out_tvalid, out_tdata, DEPTH, DEPTH);
      end
      drain();
   endtask

   task automatic test_aclken();
      int             n = 0;
      logic [OCCW-1:0] occ_s;
      logic [31:0]     dat_s;
      logic            vld_s;
      out_tready = 1'b1;
      in_tvalid  = 1'b1;
      for (int c = 0; c < DEPTH + 2; c++) begin
         drv = mk_beat(300 + n);
         step();
         if (last_in_xfer) n++;
      end
      occ_s  = occupancy;
      dat_s  = out_tdata;
      vld_s  = out_tvalid;
      aclken = 1'b0;
      drv    = mk_beat(300 + n);
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (occupancy !== occ_s || out_tdata !== dat_s || out_tvalid !== vld_s || in_tready !== 1'b1) begin
            failures++;
            $display("FAIL aclken_freeze: got occ=%0d data=%h valid=%b ready=%b expected %0d/%h/%b/1",
                     occupancy, out_tdata, out_tvalid, in_tready, occ_s, dat_s, vld_s);
         end
      end
      aclken = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drv = mk_beat(300 + n);
         step();
         if (last_in_xfer) n++;
      end
      drain();
   endtask

   task automatic test_reset_mid();
      out_tready = 1'b0;
      in_tvalid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drv = mk_beat(400 + i);
         step();
      end
      in_tvalid = 1'b0;
      for (int i = 0; i < DEPTH - 2; i++) step();
      checks++;
      if (occupancy !== OCCW'(2) || out_tvalid !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_pre: got occ=%0d valid=%b expected 2/1", occupancy, out_tvalid);
      end
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if (out_tvalid !== 1'b0 || occupancy !== '0 || out_tdata !== '0) begin
         failures++;
         $display("FAIL reset_mid_async: got valid=%b occ=%0d data=%h expected 0/0/0", out_tvalid, occupancy, out_tdata);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      exp_q.delete();
      hold_pending = 1'b0;
      test_latency(32'h5A5A_0002);
   endtask

   task automatic test_random();
      in_tvalid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_tvalid || last_in_xfer) begin
            in_tvalid = 1'($urandom_range(0, 1));
            drv       = rand_beat();
         end
         out_tready = ($urandom_range(0, 99) < 65);
         aclken     = ($urandom_range(0, 9) != 0);
         step();
      end
      drain();
   endtask

   initial begin
      last_in_xfer  = 1'b0;
      last_out_xfer = 1'b0;
      hold_pending  = 1'b0;
      held_beat     = '0;
      test_reset();
      test_latency(32'hA5A5_0001);
      test_throughput();
      test_backpressure();
      test_bubble();
      test_aclken();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
